// File: rtl/uart_rx_ctrl.sv
// UART receive frame sequencer: start detect, bit timing, field assembly, error flags.
// Latency: data_valid/stp_err one cycle after the last stop-bit tick; par_err one cycle after the parity bit end.
// Backpressure: none; the serial line cannot be stalled, every strobe is a single cycle.
//
// Ports:
//   CLK, RST        oversampling clock; synchronous active-low reset
//   RX_IN           serial line (idle high)
//   Prescale        ticks per bit (4/8/16/32), captured at start detect
//   PAR_EN/PAR_TYP  parity enable / odd(1) or even(0), captured at start detect
//   sampled_bit     majority-voted bit from the data sampler
//   dat_samp_en     sampler enable, high whenever a frame is in progress
//   edge_cnt        tick index within the current bit
//   P_DATA          last good received word
//   data_valid      1-cycle strobe, P_DATA updated
//   par_err/stp_err 1-cycle error strobes
//   err_cnt         (only with UART_RX_ERR_CNT_EN) saturating count of bad frames
module uart_rx_ctrl #(
  parameter int Prescale_Width = 6,
  parameter int DATA_WIDTH     = 8
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RX_IN,
  input  logic [Prescale_Width-1:0] Prescale,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic                      sampled_bit,
  output logic                      dat_samp_en,
  output logic [Prescale_Width-1:0] edge_cnt,
  output logic [DATA_WIDTH-1:0]     P_DATA,
  output logic                      data_valid,
  output logic                      par_err,
  output logic                      stp_err
`ifdef UART_RX_ERR_CNT_EN
  ,
  output logic [7:0]                err_cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic [Prescale_Width-1:0] EDGE_ONE = Prescale_Width'(1);
  localparam logic [3:0]                LAST_BIT = 4'(DATA_WIDTH - 1);

  state_t                      state;
  state_t                      next_state;
  logic [Prescale_Width-1:0]   presc_q;
  logic                        par_en_q;
  logic                        par_typ_q;
  logic [3:0]                  bit_cnt;
  logic [DATA_WIDTH-1:0]       shift_reg;
  logic                        bad_frame;
  logic                        bit_end;
  logic                        par_mismatch;

  // Bit timing uses the prescale captured for this frame, not the live input.
  assign bit_end      = (edge_cnt == (presc_q - EDGE_ONE));
  assign par_mismatch = (sampled_bit != ((^shift_reg) ^ par_typ_q));

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state  = state;
    dat_samp_en = 1'b1;
    case (state)
      IDLE: begin
        dat_samp_en = 1'b0;
        if (!RX_IN) begin
          next_state = START;
        end
      end
      START: begin
        // A start bit that votes high was a glitch: drop it silently.
        if (bit_end) begin
          next_state = sampled_bit ? IDLE : DATA;
        end
      end
      DATA: begin
        if (bit_end && (bit_cnt == LAST_BIT)) begin
          next_state = par_en_q ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (bit_end) begin
          next_state = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      edge_cnt   <= '0;
      bit_cnt    <= '0;
      bad_frame  <= 1'b0;
      presc_q    <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      shift_reg  <= '0;
      P_DATA     <= '0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
      if (state == IDLE) begin
        bit_cnt   <= '0;
        bad_frame <= 1'b0;
        // The detection cycle is tick 0 of the start bit, so the next tick is 1.
        if (!RX_IN) begin
          edge_cnt  <= EDGE_ONE;
          presc_q   <= Prescale;
          par_en_q  <= PAR_EN;
          par_typ_q <= PAR_TYP;
        end else begin
          edge_cnt <= '0;
        end
      end else begin
        edge_cnt <= bit_end ? '0 : (edge_cnt + EDGE_ONE);
        if (bit_end) begin
          case (state)
            DATA: begin
              for (int i = 0; i < DATA_WIDTH; i++) begin
                if (bit_cnt == 4'(i)) begin
                  shift_reg[i] <= sampled_bit;
                end
              end
              bit_cnt <= bit_cnt + 4'd1;
            end
            PARITY: begin
              if (par_mismatch) begin
                bad_frame <= 1'b1;
                par_err   <= 1'b1;
              end
            end
            STOP: begin
              if (!sampled_bit) begin
                stp_err <= 1'b1;
              end else if (!bad_frame) begin
                P_DATA     <= shift_reg;
                data_valid <= 1'b1;
              end
            end
            default: begin
            end
          endcase
        end
      end
    end
  end

`ifdef UART_RX_ERR_CNT_EN
  // One increment per bad frame: at the parity strobe, or at the stop strobe
  // only if parity had not already marked the frame bad.
  logic err_event;

  always_comb begin
    err_event = 1'b0;
    if (bit_end) begin
      if ((state == PARITY) && par_mismatch) begin
        err_event = 1'b1;
      end
      if ((state == STOP) && !sampled_bit && !bad_frame) begin
        err_event = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      err_cnt <= 8'd0;
    end else if (err_event && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: directed frames plus randomized frames against a cycle-indexed expectation model.
// Latency: expectations are scheduled per absolute cycle from frame start, length and field contents.
// Backpressure: none; the line model drives one bit value per Prescale cycles.
module tb_uart_rx_ctrl;

  localparam int PW = 6;
  localparam int DW = 8;
  localparam int NC = 30000;

  logic          CLK;
  logic          RST;
  logic          RX_IN;
  logic [PW-1:0] Prescale;
  logic          PAR_EN;
  logic          PAR_TYP;
  logic          sampled_bit;
  logic          dat_samp_en;
  logic [PW-1:0] edge_cnt;
  logic [DW-1:0] P_DATA;
  logic          data_valid;
  logic          par_err;
  logic          stp_err;
`ifdef UART_RX_ERR_CNT_EN
  logic [7:0]    err_cnt;
`endif

  uart_rx_ctrl #(.Prescale_Width(PW), .DATA_WIDTH(DW)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .RX_IN       (RX_IN),
    .Prescale    (Prescale),
    .PAR_EN      (PAR_EN),
    .PAR_TYP     (PAR_TYP),
    .sampled_bit (sampled_bit),
    .dat_samp_en (dat_samp_en),
    .edge_cnt    (edge_cnt),
    .P_DATA      (P_DATA),
    .data_valid  (data_valid),
    .par_err     (par_err),
    .stp_err     (stp_err)
`ifdef UART_RX_ERR_CNT_EN
    ,
    .err_cnt     (err_cnt)
`endif
  );

  // Ideal sampler: the line is held constant over each bit period.
  assign sampled_bit = RX_IN;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  // Expected behaviour, indexed by absolute cycle.
  bit  exp_dv   [NC];
  bit  exp_pe   [NC];
  bit  exp_se   [NC];
  bit  exp_busy [NC];
  int  exp_edge [NC];
  int  pdata_upd[NC];
  bit  err_inc  [NC];
  bit  err_clr  [NC];
  logic [DW-1:0] exp_pdata = '0;
  int  exp_err = 0;
  bit  check_on = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (check_on) begin
      if (pdata_upd[cyc] >= 0) exp_pdata = DW'(pdata_upd[cyc]);
      check_eq("data_valid", 32'(data_valid), 32'(exp_dv[cyc]));
      check_eq("par_err", 32'(par_err), 32'(exp_pe[cyc]));
      check_eq("stp_err", 32'(stp_err), 32'(exp_se[cyc]));
      check_eq("dat_samp_en", 32'(dat_samp_en), 32'(exp_busy[cyc]));
      check_eq("edge_cnt", 32'(edge_cnt), exp_edge[cyc]);
      check_eq("P_DATA", 32'(P_DATA), 32'(exp_pdata));
`ifdef UART_RX_ERR_CNT_EN
      if (err_clr[cyc]) exp_err = 0;
      if (err_inc[cyc] && exp_err < 255) exp_err++;
      check_eq("err_cnt", 32'(err_cnt), exp_err);
`endif
    end
  end

  // Forget everything scheduled from cycle r on; reset lands in cycle r.
  task automatic clear_from(input int r);
    for (int i = r; i < NC; i++) begin
      exp_dv[i] = 1'b0; exp_pe[i] = 1'b0; exp_se[i] = 1'b0;
      exp_busy[i] = 1'b0; exp_edge[i] = 0; pdata_upd[i] = -1;
      err_inc[i] = 1'b0; err_clr[i] = 1'b0;
    end
    pdata_upd[r] = 0;
    err_clr[r] = 1'b1;
  endtask

  task automatic scramble_cfg();
    Prescale = 6'(4 << $urandom_range(0, 3));
    PAR_EN   = 1'($urandom_range(0, 1));
    PAR_TYP  = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input int n);
    RX_IN = 1'b1;
    repeat (n) begin
      @(posedge CLK); #1;
    end
  endtask

  // Drive one frame starting in the current cycle; abort_at >= 0 pulses RST in that frame cycle.
  task automatic send_frame(input logic [DW-1:0] data, input int p, input bit pen, input bit ptyp,
                            input bit bad_par, input bit stop_val, input int abort_at);
    bit bits[DW+3];
    int s, nb, f, c;
    bit par_bad;
    Prescale = 6'(p);
    PAR_EN   = pen;
    PAR_TYP  = ptyp;
    s  = cyc;
    nb = 2 + DW + (pen ? 1 : 0);
    f  = nb * p;
    bits[0] = 1'b0;
    for (int i = 0; i < DW; i++) bits[1+i] = data[i];
    if (pen) bits[DW+1] = (^data) ^ ptyp ^ bad_par;
    bits[nb-1] = stop_val;
    par_bad = pen && bad_par;
    for (int k = 0; k < f; k++) begin
      exp_edge[s+k] = k % p;
      if (k > 0) exp_busy[s+k] = 1'b1;
    end
    if (par_bad) begin
      exp_pe[s+f-p]  = 1'b1;
      err_inc[s+f-p] = 1'b1;
    end
    if (!stop_val) begin
      exp_se[s+f] = 1'b1;
      if (!par_bad) err_inc[s+f] = 1'b1;
    end else if (!par_bad) begin
      exp_dv[s+f]    = 1'b1;
      pdata_upd[s+f] = int'(data);
    end
    c = 0;
    for (int b = 0; b < nb; b++) begin
      for (int k = 0; k < p; k++) begin
        RX_IN = bits[b];
        if (c == abort_at) RST = 1'b0;
        @(posedge CLK); #1;
        if (c == abort_at) begin
          RST   = 1'b1;
          RX_IN = 1'b1;
          clear_from(s + c + 1);
          return;
        end
        // The controller must ignore configuration changes mid-frame.
        if (c == 0) scramble_cfg();
        c++;
      end
    end
  endtask

  task automatic glitch(input int p, input int low);
    int s;
    Prescale = 6'(p);
    s = cyc;
    for (int k = 0; k < p; k++) begin
      exp_edge[s+k] = k % p;
      if (k > 0) exp_busy[s+k] = 1'b1;
    end
    for (int k = 0; k < p; k++) begin
      RX_IN = (k < low) ? 1'b0 : 1'b1;
      @(posedge CLK); #1;
    end
  endtask

  int rp;

  initial begin
    for (int i = 0; i < NC; i++) begin
      exp_dv[i] = 1'b0; exp_pe[i] = 1'b0; exp_se[i] = 1'b0;
      exp_busy[i] = 1'b0; exp_edge[i] = 0; pdata_upd[i] = -1;
      err_inc[i] = 1'b0; err_clr[i] = 1'b0;
    end
    RST = 1'b0; RX_IN = 1'b1; Prescale = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_eq("rst_data_valid", 32'(data_valid), 32'd0);
    check_eq("rst_par_err", 32'(par_err), 32'd0);
    check_eq("rst_stp_err", 32'(stp_err), 32'd0);
    check_eq("rst_P_DATA", 32'(P_DATA), 32'd0);
    check_eq("rst_edge_cnt", 32'(edge_cnt), 32'd0);
    check_eq("rst_dat_samp_en", 32'(dat_samp_en), 32'd0);
    @(posedge CLK); #1;
    RST = 1'b1;
    check_on = 1'b1;
    idle(3);

    // Good frame, no parity: data_valid 80 cycles after detection.
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1); idle(4);
    // Even parity, correct parity bit: data_valid at 88.
    send_frame(8'h3C, 8, 1'b1, 1'b0, 1'b0, 1'b1, -1); idle(2);
    // Wrong parity bit: par_err at 80, P_DATA keeps 0x3C.
    send_frame(8'h3C, 8, 1'b1, 1'b0, 1'b1, 1'b1, -1); idle(2);
    // Odd parity, correct bit.
    send_frame(8'h71, 8, 1'b1, 1'b1, 1'b0, 1'b1, -1); idle(2);
    // Start glitch of two cycles.
    glitch(8, 2); idle(3);
    // Framing error, line then returns high.
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b0, -1); idle(3);
    // Back-to-back frames at Prescale 4.
    send_frame(8'h01, 4, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    send_frame(8'hFF, 4, 1'b0, 1'b0, 1'b0, 1'b1, -1); idle(2);
    // Break: bad stop with the line held low becomes the next start bit.
    send_frame(8'h00, 8, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    send_frame(8'hE7, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1); idle(2);
    // Reset in the middle of data bit 3, then a normal frame.
    send_frame(8'h96, 8, 1'b0, 1'b0, 1'b0, 1'b1, 4 * 8 + 4); idle(4);
    send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1); idle(3);

    for (int n = 0; n < 40; n++) begin
      if (cyc > NC - 1200) break;
      rp = 4 << $urandom_range(0, 3);
      if ($urandom_range(0, 7) == 0) begin
        glitch(rp, int'($urandom_range(1, rp / 2)));
      end else begin
        send_frame(8'($urandom), rp, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) != 0), -1);
      end
      idle(int'($urandom_range(0, 3)));
    end
    idle(4);
    check_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Frame-sequencing controller for the UART receiver. It detects the start bit, runs the per-bit edge counter, and enables the oversampling data sampler. It consumes the sampler's majority-voted `sampled_bit` at the end of every bit period and assembles start/data/parity/stop fields. It presents received bytes on `P_DATA` with a one-cycle `data_valid` strobe, or flags parity and stop errors.

## Interface
- `Prescale_Width`, default 6: width of `Prescale` and `edge_cnt`.
- `DATA_WIDTH`, default 8: data bits per frame, 1..15.
- `CLK` input, 1 bit: oversampling clock, Prescale ticks per bit.
- `RST` input, 1 bit: reset, synchronous, active-low. Clock is `CLK`.
- `RX_IN` input, 1 bit: serial line, idle high.
- `Prescale` input, `Prescale_Width` bits: oversampling ratio. Legal values are 4, 8, 16, 32.
- `PAR_EN` input, 1 bit: 1 means the frame carries a parity bit.
- `PAR_TYP` input, 1 bit: 0 means even parity, 1 means odd parity.
- `sampled_bit` input, 1 bit: voted bit from the data sampler.
- `dat_samp_en` output, 1 bit: sampler enable.
- `edge_cnt` output, `Prescale_Width` bits: tick index within the current bit, 0..Prescale-1.
- `P_DATA` output, `DATA_WIDTH` bits: last good received word.
- `data_valid` output, 1 bit: one-cycle strobe, `P_DATA` is new.
- `par_err` output, 1 bit: one-cycle strobe, parity mismatch.
- `stp_err` output, 1 bit: one-cycle strobe, stop bit sampled 0.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- `dat_samp_en` is 1 in every state except IDLE, decoded combinationally from the state.
- IDLE holds `edge_cnt` at 0.
  - When `RX_IN`=0 is seen, the controller latches `Prescale`, `PAR_EN` and `PAR_TYP` for the frame and goes to START with `edge_cnt`<=1. The detection cycle counts as edge 0.
- Outside IDLE, `edge_cnt` increments every cycle and wraps from Prescale-1 to 0.
- A "bit end" is the cycle where `edge_cnt`==Prescale-1. All decisions are taken only at bit ends, using `sampled_bit`.
- START: if `sampled_bit`==0, go to DATA. If it is 1, the start was a glitch: go to IDLE with no strobes.
- DATA:
  - The internal bit counter counts 0..DATA_WIDTH-1.
  - Bit i is written to shift register position i (LSB first).
  - After bit DATA_WIDTH-1, go to PARITY if `PAR_EN`=1, else go to STOP.
- PARITY: the expected bit is XOR of the data bits, inverted when `PAR_TYP`=1.
  - On mismatch, set an internal bad-frame flag and pulse `par_err`.
  - Always go to STOP.
- STOP, then IDLE:
  - If `sampled_bit`=0, pulse `stp_err`.
  - If `sampled_bit`=1 and the bad-frame flag is clear, load `P_DATA` from the shift register and pulse `data_valid`.
- `P_DATA` holds its value until the next good frame. Bad frames never modify it.
- A break (stop bit sampled 0, `RX_IN` still low) is re-detected as a new start bit in the first IDLE cycle. This is the required behaviour.
- `RST`=0 at any clock edge takes priority over everything:
  - next state IDLE, `edge_cnt`=0, bit counter 0, bad-frame flag 0;
  - `P_DATA`=0, `data_valid`=0, `par_err`=0, `stp_err`=0.
  - An aborted frame produces no strobes.

## Timing
- All outputs except `dat_samp_en` are registered.
- Frame length is F = (2 + DATA_WIDTH + PAR_EN) × Prescale cycles, counting from the detection cycle (cycle 0).
- `data_valid`/`stp_err` are high during cycle F, which is the first IDLE cycle.
- `par_err` is high during the first STOP cycle.
- A new start edge is accepted in cycle F itself, so back-to-back frames have zero gap.
- `Prescale` changes while not in IDLE are ignored by the controller until the next frame. The sampler sees the live value, so the source must keep it static during a frame.

## Configuration
- Macro: `UART_RX_ERR_CNT_EN`.
- When defined, the block adds an output port `err_cnt` [7:0].
  - It is a saturating count of frames ending with `par_err` or `stp_err`. A frame with both errors counts once.
  - It increments in the strobe cycle, stops at 255, and resets to 0.
- When not defined, the port and its logic are absent and behaviour is otherwise identical.

## Test plan
- Good frame: `Prescale`=8, `PAR_EN`=0, line sends 0xA5 → `data_valid`=1 only at cycle 80, `P_DATA`=0xA5, no error strobes.
- Parity: `Prescale`=8, `PAR_EN`=1, even parity, 0x3C.
  - Parity bit 0 → `data_valid` at cycle 88.
  - Parity bit 1 → `par_err` at cycle 80, no `data_valid`, `P_DATA` unchanged.
- Glitch: `RX_IN` low for 2 cycles at `Prescale`=8 → IDLE after edge 7, `dat_samp_en` low from cycle 8, no strobes.
- Framing error: stop bit driven 0, line then returns high → `stp_err` pulse, no `data_valid`. With `UART_RX_ERR_CNT_EN`, `err_cnt` goes 0→1.
- Back-to-back: `Prescale`=4, frames 0x01 then 0xFF with no idle gap → `data_valid` at cycles 40 and 80 with matching `P_DATA`.
- Reset mid-frame: `RST`=0 during DATA bit 3 → next cycle IDLE, `edge_cnt`=0, `dat_samp_en`=0, all outputs 0. The following good frame is received normally.
